// File: rtl/mdu_iter_if.sv
// EX-stage multi-cycle handshake between the pipeline (master) and the
// iterative multiply/divide unit (slave).
interface mdu_iter_if #(
    parameter int XLEN = 32
);
    logic            start;
    logic            stall;
    logic [2:0]      op;
    logic [XLEN-1:0] A;
    logic [XLEN-1:0] B;
    logic            eoc;
    logic            busy;
    logic [XLEN-1:0] res;

    modport master (
        output start, stall, op, A, B,
        input  eoc, busy, res
    );

    modport slave (
        input  start, stall, op, A, B,
        output eoc, busy, res
    );
endinterface

// File: rtl/mdu_iter.sv
// Iterative RV32M multiply/divide: radix-2 shift-add multiply and restoring
// divide on operand magnitudes, with sign correction in a final FIX cycle.
//
// state | meaning
// IDLE  | waiting for start, no result held yet
// ITER  | 32 one-bit multiply or divide steps
// FIX   | select result half/quotient/remainder and apply sign
// DONE  | res valid, eoc high; a new start is accepted directly
module mdu_iter #(
    parameter int XLEN         = 32,
    parameter bit FAST_SPECIAL = 1'b1
) (
    input  logic       clk,
    input  logic       reset_n,
    mdu_iter_if.slave  bus
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ITER = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t          state, state_nxt;
    logic [2:0]      op_q, op_d;
    logic [XLEN-1:0] b_q, b_d;
    logic            sign_q, sign_d;
    logic [4:0]      count_q, count_d;
    logic [64:0]     acc_q, acc_d;
    logic [XLEN-1:0] res_q, res_d;

    // Operand decode at the start edge, on the raw bus operands
    logic            a_signed, b_signed, sa, sb, b_zero, ovf, special;
    logic [31:0]     a_mag_in, b_mag_in, special_res;
    logic            sign_in;

    assign a_signed = (bus.op == 3'd1) || (bus.op == 3'd2) ||
                      (bus.op == 3'd4) || (bus.op == 3'd6);
    assign b_signed = (bus.op == 3'd1) || (bus.op == 3'd4) || (bus.op == 3'd6);
    assign sa       = a_signed & bus.A[31];
    assign sb       = b_signed & bus.B[31];
    assign a_mag_in = sa ? (~bus.A + 32'd1) : bus.A;
    assign b_mag_in = sb ? (~bus.B + 32'd1) : bus.B;
    assign b_zero   = (bus.B == 32'd0);
    assign ovf      = ((bus.op == 3'd4) || (bus.op == 3'd6)) &&
                      (bus.A == 32'h8000_0000) && (bus.B == 32'hFFFF_FFFF);
    assign special  = FAST_SPECIAL && bus.op[2] && (b_zero || ovf);
    assign special_res = b_zero ? (bus.op[1] ? bus.A : 32'hFFFF_FFFF)
                                : (bus.op[1] ? 32'd0 : 32'h8000_0000);

    // Divide by zero must leave the all-ones quotient unsigned, so the
    // iterative path matches the fast path for negative dividends too.
    assign sign_in = bus.op[2] ? (bus.op[1] ? sa : (b_zero ? 1'b0 : (sa ^ sb)))
                               : (sa ^ sb);

    // Multiply step: acc = {carry, hi, lo}; carry is always 0 between steps
    logic [32:0] mul_sum;
    logic [64:0] mul_nxt;
    assign mul_sum = acc_q[64:32] + (acc_q[0] ? {1'b0, b_q} : 33'd0);
    assign mul_nxt = {1'b0, mul_sum, acc_q[31:1]};

    // Restoring divide step: acc[63:32] = remainder, acc[31:0] = quotient
    logic [64:0] div_sh, div_nxt;
    logic [32:0] rem_sh;
    logic [31:0] rem_sub;
    logic        rem_ge;
    assign div_sh  = {acc_q[63:0], 1'b0};
    assign rem_sh  = div_sh[64:32];
    assign rem_ge  = (rem_sh >= {1'b0, b_q});
    assign rem_sub = rem_sh[31:0] - b_q;
    assign div_nxt = rem_ge ? {1'b0, rem_sub, div_sh[31:1], 1'b1}
                            : {1'b0, rem_sh[31:0], div_sh[31:0]};

    // Sign fix-up and result selection
    logic [63:0] prod_s;
    logic [31:0] quo_s, rem_s, fix_res;
    assign prod_s = sign_q ? (~acc_q[63:0] + 64'd1) : acc_q[63:0];
    assign quo_s  = sign_q ? (~acc_q[31:0] + 32'd1) : acc_q[31:0];
    assign rem_s  = sign_q ? (~acc_q[63:32] + 32'd1) : acc_q[63:32];

    always_comb begin
        fix_res = rem_s;
        case (op_q)
            3'd0:             fix_res = prod_s[31:0];
            3'd1, 3'd2, 3'd3: fix_res = prod_s[63:32];
            3'd4, 3'd5:       fix_res = quo_s;
            default:          fix_res = rem_s;
        endcase
    end

    always_comb begin
        state_nxt = state;
        op_d      = op_q;
        b_d       = b_q;
        sign_d    = sign_q;
        count_d   = count_q;
        acc_d     = acc_q;
        res_d     = res_q;
        if (!bus.stall) begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (bus.start) begin
                        op_d    = bus.op;
                        b_d     = b_mag_in;
                        sign_d  = sign_in;
                        count_d = 5'd0;
                        acc_d   = {33'd0, a_mag_in};
                        if (special) begin
                            res_d     = special_res;
                            state_nxt = S_DONE;
                        end else begin
                            state_nxt = S_ITER;
                        end
                    end
                end
                S_ITER: begin
                    acc_d   = op_q[2] ? div_nxt : mul_nxt;
                    count_d = count_q + 5'd1;
                    if (count_q == 5'd31) state_nxt = S_FIX;
                end
                S_FIX: begin
                    res_d     = fix_res;
                    state_nxt = S_DONE;
                end
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state   <= S_IDLE;
            op_q    <= 3'd0;
            b_q     <= '0;
            sign_q  <= 1'b0;
            count_q <= 5'd0;
            acc_q   <= '0;
            res_q   <= '0;
        end else begin
            state   <= state_nxt;
            op_q    <= op_d;
            b_q     <= b_d;
            sign_q  <= sign_d;
            count_q <= count_d;
            acc_q   <= acc_d;
            res_q   <= res_d;
        end
    end

    assign bus.eoc  = (state == S_DONE);
    assign bus.busy = (state == S_ITER) || (state == S_FIX);
    assign bus.res  = res_q;
endmodule

// File: tb/tb_mdu_iter.sv
// Directed bench for mdu_iter: one instance with fast special cases, one
// without; expected results/latencies are queued at start, checked at eoc.
module tb_mdu_iter;
    logic clk = 1'b0;
    logic reset_n = 1'b0;

    always #5 clk = ~clk;

    mdu_iter_if bus_f ();
    mdu_iter_if bus_s ();

    mdu_iter #(.XLEN(32), .FAST_SPECIAL(1'b1)) dut_f (
        .clk(clk), .reset_n(reset_n), .bus(bus_f.slave)
    );
    mdu_iter #(.XLEN(32), .FAST_SPECIAL(1'b0)) dut_s (
        .clk(clk), .reset_n(reset_n), .bus(bus_s.slave)
    );

    typedef struct {
        logic [31:0] res;
        int          lat;
    } exp_t;

    exp_t sb[$];
    int vectors = 0;
    int miscompares = 0;

    localparam logic [2:0] MUL = 3'd0, MULH = 3'd1, MULHSU = 3'd2, MULHU = 3'd3;
    localparam logic [2:0] DIV = 3'd4, DIVU = 3'd5, REM = 3'd6, REMU = 3'd7;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit slow, input logic st, input logic [2:0] op,
                         input logic [31:0] a, input logic [31:0] b);
        if (slow) begin
            bus_s.start = st; bus_s.op = op; bus_s.A = a; bus_s.B = b;
        end else begin
            bus_f.start = st; bus_f.op = op; bus_f.A = a; bus_f.B = b;
        end
    endtask

    task automatic set_stall(input logic v);
        bus_f.stall = v;
        bus_s.stall = v;
    endtask

    function automatic logic get_eoc(input bit slow);
        return slow ? bus_s.eoc : bus_f.eoc;
    endfunction

    function automatic logic get_busy(input bit slow);
        return slow ? bus_s.busy : bus_f.busy;
    endfunction

    function automatic logic [31:0] get_res(input bit slow);
        return slow ? bus_s.res : bus_f.res;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One operation; optional stall of stall_len cycles starting in cycle stall_at
    task automatic run(input string tag, input bit slow, input logic [2:0] op,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp_res, input int exp_lat,
                       input int stall_at, input int stall_len);
        exp_t e;
        int   cyc;
        int   busy_bad;
        sb.push_back('{res: exp_res, lat: exp_lat});
        drive(slow, 1'b1, op, a, b);
        tick();
        drive(slow, 1'b0, 3'($urandom_range(0, 7)), $urandom, $urandom);
        cyc = 1;
        busy_bad = 0;
        while (!get_eoc(slow) && cyc < 200) begin
            if (get_busy(slow) !== 1'b1) busy_bad++;
            if (stall_len > 0 && cyc == stall_at) set_stall(1'b1);
            if (stall_len > 0 && cyc == stall_at + stall_len) set_stall(1'b0);
            if (stall_len > 0 && cyc > stall_at && cyc < stall_at + stall_len)
                check({tag, " eoc_in_stall"}, 32'(get_eoc(slow)), 32'd0);
            tick();
            cyc++;
        end
        set_stall(1'b0);
        e = sb.pop_front();
        check({tag, " latency"}, 32'(cyc), 32'(e.lat));
        check({tag, " res"}, get_res(slow), e.res);
        check({tag, " busy_window"}, 32'(busy_bad), 32'd0);
        check({tag, " busy_at_eoc"}, 32'(get_busy(slow)), 32'd0);
    endtask

    // The EX side must never raise an unstalled start while the unit is busy
    always @(posedge clk) begin
        if (reset_n && bus_f.start && bus_f.busy && !bus_f.stall) begin
            miscompares++;
            $error("FAIL start_while_busy: observed start=1 expected start=0");
        end
    end

    initial begin
        int eoc_seen;
        set_stall(1'b0);
        drive(1'b0, 1'b0, MUL, 32'd0, 32'd0);
        drive(1'b1, 1'b0, MUL, 32'd0, 32'd0);
        reset_n = 1'b0;
        repeat (3) tick();
        check("reset eoc", 32'(bus_f.eoc), 32'd0);
        check("reset busy", 32'(bus_f.busy), 32'd0);
        check("reset res", bus_f.res, 32'd0);
        check("reset res slow", bus_s.res, 32'd0);
        reset_n = 1'b1;
        tick();

        run("MUL 7*-3",   1'b0, MUL,    32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFEB, 34, 0, 0);
        run("MULH min^2", 1'b0, MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 34, 0, 0);
        run("MULHU max",  1'b0, MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 34, 0, 0);
        run("MULHSU",     1'b0, MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 34, 0, 0);
        run("DIV -7/2",   1'b0, DIV,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 34, 0, 0);
        run("REM -7%2",   1'b0, REM,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 34, 0, 0);
        run("DIVU 100/7", 1'b0, DIVU,   32'd100,       32'd7,         32'd14,        34, 0, 0);
        run("REMU 100%7", 1'b0, REMU,   32'd100,       32'd7,         32'd2,         34, 0, 0);

        run("fast DIV 5/0",  1'b0, DIV, 32'd5,         32'd0,         32'hFFFF_FFFF, 1, 0, 0);
        run("fast REM 5/0",  1'b0, REM, 32'd5,         32'd0,         32'd5,         1, 0, 0);
        run("fast DIV ovf",  1'b0, DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, 0, 0);
        run("fast REM ovf",  1'b0, REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1, 0, 0);
        run("slow DIV 5/0",  1'b1, DIV, 32'd5,         32'd0,         32'hFFFF_FFFF, 34, 0, 0);
        run("slow REM 5/0",  1'b1, REM, 32'd5,         32'd0,         32'd5,         34, 0, 0);
        run("slow DIV ovf",  1'b1, DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 34, 0, 0);
        run("slow REM ovf",  1'b1, REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         34, 0, 0);

        run("stall MUL 3*5", 1'b0, MUL, 32'd3, 32'd5, 32'd15, 44, 10, 10);

        // Start raised while stalled in DONE must not be taken
        set_stall(1'b1);
        drive(1'b0, 1'b1, MUL, 32'd2, 32'd2);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall DONE eoc", 32'(bus_f.eoc), 32'd1);
            check("stall DONE res", bus_f.res, 32'd15);
        end
        drive(1'b0, 1'b0, MUL, 32'd0, 32'd0);
        set_stall(1'b0);
        tick();
        check("stall start ignored eoc", 32'(bus_f.eoc), 32'd1);
        check("stall start ignored busy", 32'(bus_f.busy), 32'd0);

        // Reset in cycle 12 of a DIV aborts it
        drive(1'b0, 1'b1, DIV, 32'd1000, 32'd7);
        tick();
        drive(1'b0, 1'b0, DIV, 32'd0, 32'd0);
        repeat (11) tick();
        reset_n = 1'b0;
        tick();
        check("abort eoc", 32'(bus_f.eoc), 32'd0);
        check("abort busy", 32'(bus_f.busy), 32'd0);
        check("abort res", bus_f.res, 32'd0);
        reset_n = 1'b1;
        eoc_seen = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (bus_f.eoc) eoc_seen++;
        end
        check("abort no eoc", 32'(eoc_seen), 32'd0);
        run("DIVU 9/3", 1'b0, DIVU, 32'd9, 32'd3, 32'd3, 34, 0, 0);

        // Back-to-back: second start issued while the first is in DONE
        run("b2b MUL 6*7",   1'b0, MUL, 32'd6,          32'd7, 32'd42,         34, 0, 0);
        run("b2b DIV -20/3", 1'b0, DIV, 32'hFFFF_FFEC,  32'd3, 32'hFFFF_FFFA,  34, 0, 0);
        run("b2b REM -20%3", 1'b0, REM, 32'hFFFF_FFEC,  32'd3, 32'hFFFF_FFFE,  34, 0, 0);

        check("scoreboard empty", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/mdu_iter.md
Name: mdu_iter

Overview:
- Iterative RV32M multiply/divide unit for the EX stage.
- It is the responder side of the EX multi-cycle handshake (start / stall / eoc): EX raises start and holds its stall request until eoc.
- Radix-2 shift-add multiply and restoring divide, one bit per cycle, with operand sign correction in a final fix-up cycle.
- Replaces a combinational multiplier so that timing closes on FPGA.

Parameters:
- XLEN, 32, operand/result width; only 32 is supported.
- FAST_SPECIAL, 1, when 1, divide-by-zero and signed overflow complete without iterating.

Ports:
- clk  in  1  clock
- reset_n  in  1  synchronous, active-low reset
- start  in  1  begin operation; sampled only when !stall
- stall  in  1  external pipeline stall; freezes all state
- op  in  3  funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
- A  in  32  rs1 operand; sampled with start
- B  in  32  rs2 operand; sampled with start
- eoc  out  1  result valid; high exactly while state is DONE
- busy  out  1  high in ITER or FIX
- res  out  32  result; valid while eoc is high

Behaviour:
- Reset: state IDLE, eoc=0, busy=0, res=0, count=0, all datapath registers 0. Reset during any state aborts the operation; no eoc follows.
- States: IDLE, ITER, FIX, DONE.
- stall=1: no register changes in any state, including start sampling. Outputs hold.
- IDLE or DONE, start=1, stall=0, edge k:
  - latch op.
  - latch |A| and |B| as magnitudes; signed treatment: A for MULH/MULHSU/DIV/REM, B for MULH/DIV/REM.
  - latch result sign: mul = sA^sB; DIV = sA^sB; REM = sA.
  - count=0; go to ITER.
  - eoc falls in the cycle after edge k.
- start while ITER or FIX: ignored; the EX side never does this (bench asserts it).
- ITER, multiply: 64-bit product register {hi, lo}, lo initialised to |A|. Each unstalled edge: if lo[0], add |B| into hi with carry into bit 64; shift right 1.
- ITER, divide: restoring division. {rem, quo} shifted left 1; if rem >= |B|, subtract and set quo[0].
- ITER exit: after 32 unstalled iterations (edge k+32) go to FIX.
- FIX (edge k+33), select, then negate when the result sign is set:
  - MUL: low 32 bits of the 64-bit signed product.
  - MULH/MULHSU/MULHU: high 32 bits, negated as a 64-bit two's complement when needed.
  - DIV/DIVU: quotient.
  - REM/REMU: remainder.
  - Write res, go to DONE.
- Nominal latency: start cycle 0, eoc first high in cycle 34 with no stalls. Each stalled cycle adds exactly one cycle.
- FAST_SPECIAL, evaluated at the start edge on raw A/B; state goes directly to DONE, eoc is high in cycle 1, res is written at edge k:
  - B=0, DIV/DIVU: res=0xFFFFFFFF.
  - B=0, REM/REMU: res=A.
  - A=0x80000000, B=0xFFFFFFFF, DIV: res=0x80000000.
  - Same operands, REM: res=0.
- When FAST_SPECIAL=0, the iterative path must produce the same special-case values.
- DONE: eoc=1, res held stable indefinitely until the next accepted start or reset.
- Back-to-back: a start in DONE is accepted directly, with no IDLE cycle required.
- Width rules: all internal adds use 33 bits; the product register is 65 bits. No overflow flags are exported.

Test Plan:
- MUL A=7, B=0xFFFFFFFD → res=0xFFFFFFEB; eoc first high exactly 34 cycles after start; busy high for cycles 1..33.
- MULH A=B=0x80000000 → 0x40000000. MULHU A=B=0xFFFFFFFF → 0xFFFFFFFE. MULHSU A=0xFFFFFFFF, B=0xFFFFFFFF → 0xFFFFFFFF.
- DIV A=0xFFFFFFF9 (-7), B=2 → 0xFFFFFFFD; REM with the same operands → 0xFFFFFFFF; DIVU A=100, B=7 → 14; REMU → 2.
- Specials with FAST_SPECIAL=1:
  - DIV 5/0 → 0xFFFFFFFF, eoc in cycle 1.
  - REM 5/0 → 5.
  - DIV 0x80000000/0xFFFFFFFF → 0x80000000.
  - REM with the same operands → 0.
  - Repeat all four with FAST_SPECIAL=0: same values, 34-cycle latency.
- Stall: MUL 3×5 with stall held high for 10 cycles mid-ITER → res=15, eoc in cycle 44. Check no state change while stalled, and that start asserted during stall in DONE is not accepted.
- Reset: assert reset_n=0 at cycle 12 of a DIV → next cycle eoc=0, busy=0, res=0. A new DIVU 9/3 then returns 3 with nominal latency. Also run back-to-back MUL→DIV with start in DONE.
